alu_seq_ctrl: RTL and testbench

Multicycle control FSM for the CPU datapath. It sequences instruction fetch, decode, execute and writeback. It drives the ALU operand-B mux selector, the ALU operand-A select, the ALU operation and the register/PC/IR write enables for the supported integer subset. It sits between the instruction register decode fields and the datapath's muxes and write enables. It also stalls fetch for a configurable number of memory wait states and traps on invalid instructions or arithmetic overflow.

---
 rtl/alu_seq_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multicycle control FSM: fetch (with memory wait states), decode, execute,
// writeback and branch sequencing for the integer subset, with sticky traps.
module alu_seq_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       mem_read,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_srca,
    output logic [2:0] alu_srcb,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       trap,
    output logic [1:0] trap_cause
);

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I,
        S_BRANCH, S_WB_R, S_WB_I, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_ANDI, K_ORI, K_BEQ, K_BNE, K_INV
    } kind_t;

    localparam logic [3:0] WAIT_LIM = 4'(MEM_WAIT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    kind_t       kind_r;
    kind_t       kind_dec_s;
    logic [1:0]  cause_r;
    logic [1:0]  cause_nxt_s;
    logic        fetch_done_s;

    function automatic kind_t decode_kind(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   k = K_ADD;
                    6'h22:   k = K_SUB;
                    6'h24:   k = K_AND;
                    6'h25:   k = K_OR;
                    default: k = K_INV;
                endcase
            end
            6'h08:   k = K_ADDI;
            6'h0C:   k = K_ANDI;
            6'h0D:   k = K_ORI;
            6'h04:   k = K_BEQ;
            6'h05:   k = K_BNE;
            default: k = K_INV;
        endcase
        return k;
    endfunction

    assign kind_dec_s   = decode_kind(opcode, funct);
    assign fetch_done_s = (cnt_r == WAIT_LIM);

    // State, wait counter, latched instruction class and trap cause
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_START;
            cnt_r   <= 4'd0;
            kind_r  <= K_INV;
            cause_r <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            cause_r <= cause_nxt_s;
            // Counter only advances while a fetch keeps waiting, so it restarts at 0 on every entry
            if (state_r == S_FETCH && !fetch_done_s) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= 4'd0;
            end
            if (state_r == S_DECODE) begin
                kind_r <= kind_dec_s;
            end else begin
                kind_r <= kind_r;
            end
        end
    end

    // Next-state and trap-cause selection
    always_comb begin
        state_nxt_s = state_r;
        cause_nxt_s = cause_r;
        case (state_r)
            S_START:  state_nxt_s = S_FETCH;
            S_FETCH: begin
                if (fetch_done_s) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (kind_dec_s)
                    K_ADD, K_SUB, K_AND, K_OR: state_nxt_s = S_EXEC_R;
                    K_ADDI, K_ANDI, K_ORI:     state_nxt_s = S_EXEC_I;
                    K_BEQ, K_BNE:              state_nxt_s = S_BRANCH;
                    default: begin
                        state_nxt_s = S_TRAP;
                        cause_nxt_s = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                if ((kind_r == K_ADD || kind_r == K_SUB) && overflow) begin
                    state_nxt_s = S_TRAP;
                    cause_nxt_s = 2'b10;
                end else begin
                    state_nxt_s = S_WB_R;
                end
            end
            S_EXEC_I: begin
                if (kind_r == K_ADDI && overflow) begin
                    state_nxt_s = S_TRAP;
                    cause_nxt_s = 2'b10;
                end else begin
                    state_nxt_s = S_WB_I;
                end
            end
            S_BRANCH: state_nxt_s = S_FETCH;
            S_WB_R:   state_nxt_s = S_FETCH;
            S_WB_I:   state_nxt_s = S_FETCH;
            S_TRAP:   state_nxt_s = S_TRAP;
            default:  state_nxt_s = S_START;
        endcase
    end

    // Moore output decode; only BRANCH pc_write looks at the live zero flag
    always_comb begin
        mem_read   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_srca   = 1'b0;
        alu_srcb   = 3'd0;
        alu_op     = 3'b000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read = 1'b1;
                if (fetch_done_s) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    alu_srcb = 3'd1;
                    alu_op   = 3'b001;
                end else begin
                    ir_write = 1'b0;
                end
            end
            S_DECODE: begin
                alu_srcb = 3'd3;
                alu_op   = 3'b001;
            end
            S_EXEC_R: begin
                alu_srca = 1'b1;
                case (kind_r)
                    K_SUB:   alu_op = 3'b010;
                    K_AND:   alu_op = 3'b011;
                    K_OR:    alu_op = 3'b100;
                    default: alu_op = 3'b001;
                endcase
            end
            S_EXEC_I: begin
                alu_srca = 1'b1;
                case (kind_r)
                    K_ANDI: begin
                        alu_srcb = 3'd4;
                        alu_op   = 3'b011;
                    end
                    K_ORI: begin
                        alu_srcb = 3'd4;
                        alu_op   = 3'b100;
                    end
                    default: begin
                        alu_srcb = 3'd2;
                        alu_op   = 3'b001;
                    end
                endcase
            end
            S_BRANCH: begin
                alu_srca = 1'b1;
                alu_op   = 3'b010;
                pc_src   = 1'b1;
                pc_write = (kind_r == K_BNE) ? ~zero : zero;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_I:  reg_write = 1'b1;
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_r;
            end
            default: trap = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl: one DUT with MEM_WAIT=0 and one
// with MEM_WAIT=3 share inputs; each step queues the expected output vector.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;

    logic       mr0, irw0, pcw0, pcs0, sa0, rw0, rd0, tr0;
    logic [2:0] sb0, op0;
    logic [1:0] tc0;
    logic       mr3, irw3, pcw3, pcs3, sa3, rw3, rd3, tr3;
    logic [2:0] sb3, op3;
    logic [1:0] tc3;
    logic [15:0] o0, o3;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .mem_read(mr0), .ir_write(irw0), .pc_write(pcw0),
        .pc_src(pcs0), .alu_srca(sa0), .alu_srcb(sb0), .alu_op(op0),
        .reg_write(rw0), .reg_dst(rd0), .trap(tr0), .trap_cause(tc0)
    );

    alu_seq_ctrl #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .mem_read(mr3), .ir_write(irw3), .pc_write(pcw3),
        .pc_src(pcs3), .alu_srca(sa3), .alu_srcb(sb3), .alu_op(op3),
        .reg_write(rw3), .reg_dst(rd3), .trap(tr3), .trap_cause(tc3)
    );

    assign o0 = {mr0, irw0, pcw0, pcs0, sa0, sb0, op0, rw0, rd0, tr0, tc0};
    assign o3 = {mr3, irw3, pcw3, pcs3, sa3, sb3, op3, rw3, rd3, tr3, tc3};

    function automatic logic [15:0] ov(input logic mr, irw, pcw, pcs, sa,
                                       input logic [2:0] sb, op,
                                       input logic rw, rd, tr, input logic [1:0] tc);
        return {mr, irw, pcw, pcs, sa, sb, op, rw, rd, tr, tc};
    endfunction

    function automatic logic [15:0] idle();
        return 16'h0000;
    endfunction
    function automatic logic [15:0] f_last();
        return ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] f_wait();
        return ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] dec();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] exr(input logic [2:0] op);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, op, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] exi(input logic [2:0] sb, input logic [2:0] op);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sb, op, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] br(input logic pcw);
        return ov(1'b0, 1'b0, pcw, 1'b1, 1'b1, 3'd0, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] wbr();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 1'b1, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] wbi();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [15:0] trp(input logic [1:0] tc);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b1, tc);
    endfunction

    // Queue expectation, advance one clock, compare the selected DUT's outputs
    task automatic chk(input string tag, input logic [15:0] e, input bit sel3);
        logic [15:0] got;
        logic [15:0] want;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = sel3 ? o3 : o0;
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic run_r(input string tag, input logic [5:0] fn, input logic [2:0] op);
        opcode = 6'h00;
        funct  = fn;
        chk({tag, "_dec"}, dec(), 1'b0);
        chk({tag, "_exec"}, exr(op), 1'b0);
        overflow = 1'b0;
        chk({tag, "_wb"}, wbr(), 1'b0);
        chk({tag, "_fetch"}, f_last(), 1'b0);
    endtask

    task automatic run_br(input string tag, input logic [5:0] opc, input logic z, input logic pcw);
        opcode = opc;
        zero   = z;
        chk({tag, "_dec"}, dec(), 1'b0);
        chk({tag, "_branch"}, br(pcw), 1'b0);
        chk({tag, "_fetch"}, f_last(), 1'b0);
        zero = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        chk({tag, "_rst"}, idle(), 1'b0);
        reset = 1'b0;
        chk({tag, "_fetch"}, f_last(), 1'b0);
    endtask

    initial begin
        // Reset release, MEM_WAIT=0
        reset = 1'b1;
        chk("rst_start", idle(), 1'b0);
        reset = 1'b0;
        chk("first_fetch", f_last(), 1'b0);

        // R-type: each returns to FETCH exactly 4 cycles later
        run_r("add", 6'h20, 3'b001);
        run_r("sub", 6'h22, 3'b010);
        opcode = 6'h00;
        funct  = 6'h24;
        chk("and_dec", dec(), 1'b0);
        chk("and_exec", exr(3'b011), 1'b0);
        overflow = 1'b1;
        chk("and_ovf_ignored", wbr(), 1'b0);
        overflow = 1'b0;
        chk("and_fetch", f_last(), 1'b0);
        run_r("or", 6'h25, 3'b100);

        // I-type andi with overflow ignored
        opcode = 6'h0C;
        chk("andi_dec", dec(), 1'b0);
        chk("andi_exec", exi(3'd4, 3'b011), 1'b0);
        overflow = 1'b1;
        chk("andi_wb", wbi(), 1'b0);
        overflow = 1'b0;
        chk("andi_fetch", f_last(), 1'b0);

        // Branches: 3-cycle latency, pc_write follows zero
        run_br("beq_z1", 6'h04, 1'b1, 1'b1);
        run_br("bne_z1", 6'h05, 1'b1, 1'b0);
        run_br("beq_z0", 6'h04, 1'b0, 1'b0);
        run_br("bne_z0", 6'h05, 1'b0, 1'b1);

        // addi overflow trap, held for 20 cycles regardless of inputs
        opcode = 6'h08;
        chk("addi_dec", dec(), 1'b0);
        chk("addi_exec", exi(3'd2, 3'b001), 1'b0);
        overflow = 1'b1;
        chk("addi_trap", trp(2'b10), 1'b0);
        for (int i = 0; i < 20; i++) begin
            opcode   = 6'($urandom_range(0, 63));
            funct    = 6'($urandom_range(0, 63));
            zero     = 1'($urandom_range(0, 1));
            overflow = 1'($urandom_range(0, 1));
            chk("trap_hold", trp(2'b10), 1'b0);
        end
        overflow = 1'b0;
        zero     = 1'b0;
        do_reset("after_ovf");

        // add overflow trap
        opcode = 6'h00;
        funct  = 6'h20;
        chk("addov_dec", dec(), 1'b0);
        chk("addov_exec", exr(3'b001), 1'b0);
        overflow = 1'b1;
        chk("addov_trap", trp(2'b10), 1'b0);
        overflow = 1'b0;
        do_reset("after_addov");

        // Invalid opcode and invalid funct trap with cause 01
        opcode = 6'h3F;
        chk("inv_dec", dec(), 1'b0);
        chk("inv_trap", trp(2'b01), 1'b0);
        chk("inv_hold", trp(2'b01), 1'b0);
        do_reset("mid_trap");
        opcode = 6'h00;
        funct  = 6'h21;
        chk("badfn_dec", dec(), 1'b0);
        chk("badfn_trap", trp(2'b01), 1'b0);
        do_reset("after_badfn");

        // MEM_WAIT=3 ori: 4-cycle fetch, 7-cycle instruction
        reset = 1'b1;
        chk("w3_rst", idle(), 1'b1);
        reset  = 1'b0;
        opcode = 6'h0D;
        chk("w3_fetch0", f_wait(), 1'b1);
        chk("w3_fetch1", f_wait(), 1'b1);
        chk("w3_fetch2", f_wait(), 1'b1);
        chk("w3_fetch3", f_last(), 1'b1);
        chk("w3_ori_dec", dec(), 1'b1);
        chk("w3_ori_exec", exi(3'd4, 3'b100), 1'b1);
        chk("w3_ori_wb", wbi(), 1'b1);
        chk("w3_refetch0", f_wait(), 1'b1);
        chk("w3_refetch1", f_wait(), 1'b1);
        // Reset mid-wait clears the counter
        reset = 1'b1;
        chk("w3_rst_midwait", idle(), 1'b1);
        reset = 1'b0;
        chk("w3_after_rst0", f_wait(), 1'b1);
        chk("w3_after_rst1", f_wait(), 1'b1);
        chk("w3_after_rst2", f_wait(), 1'b1);
        chk("w3_after_rst3", f_last(), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
